// File: rtl/arm_mc_controller.sv
// Multicycle ARM controller: 10-state FSM driving a shared-memory datapath, with stored NZCV flags.
// Latency: FETCH/DECODE take one cycle each; memory states stretch while MemReady is low.
// Backpressure: MemReady low holds FETCH/MEMRD/MEMWR; an optional timeout aborts the access back to FETCH.
module arm_mc_controller #(
   parameter bit WAIT_EN = 1'b1,
   parameter int TIMEOUT = 0,
   parameter int CNT_W   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] Instr,
   input  logic [3:0]  ALUFlags,
   input  logic        MemReady,
   output logic        MemReq,
   output logic        AdrSrc,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic [1:0]  RegSrc,
   output logic [2:0]  ImmSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [2:0]  ALUControl,
   output logic        MemErr,
   output logic [3:0]  State
);

   localparam logic [3:0] FETCH  = 4'd0;
   localparam logic [3:0] DECODE = 4'd1;
   localparam logic [3:0] MEMADR = 4'd2;
   localparam logic [3:0] MEMRD  = 4'd3;
   localparam logic [3:0] MEMWB  = 4'd4;
   localparam logic [3:0] MEMWR  = 4'd5;
   localparam logic [3:0] EXECR  = 4'd6;
   localparam logic [3:0] EXECI  = 4'd7;
   localparam logic [3:0] ALUWB  = 4'd8;
   localparam logic [3:0] BRANCH = 4'd9;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_MOV = 3'b100;

   localparam bit             TO_EN   = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   // Instr carries bits [31:12] of the instruction word.
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] cmd;
   assign cond  = Instr[19:16];
   assign op    = Instr[15:14];
   assign funct = Instr[13:8];
   assign cmd   = funct[4:1];

   // Rn and Rd fields are datapath concerns only.
   logic unused_fields;
   assign unused_fields = ^Instr[7:0];

   logic [3:0]       state, next_state;
   logic [3:0]       flags;
   logic [CNT_W-1:0] wait_cnt;
   logic             rdy, in_wait, timeout, is_cmp, cond_ok;
   logic [2:0]       alu_op;

   assign rdy     = MemReady | ~WAIT_EN;
   assign in_wait = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
   assign timeout = TO_EN && in_wait && !rdy && (wait_cnt == TO_LAST);
   assign is_cmp  = (cmd == 4'b1010);
   assign State   = state;
   assign RegSrc  = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
   assign ImmSrc  = {1'b0, op};

   // Data-processing command to ALU operation; unknown commands fall back to ADD.
   always_comb begin
      alu_op = ALU_ADD;
      case (cmd)
         4'b0100: alu_op = ALU_ADD;
         4'b0010: alu_op = ALU_SUB;
         4'b1010: alu_op = ALU_SUB;
         4'b0000: alu_op = ALU_AND;
         4'b1100: alu_op = ALU_ORR;
         4'b1101: alu_op = ALU_MOV;
         default: alu_op = ALU_ADD;
      endcase
   end

   // ARM condition check against the stored NZCV flags.
   always_comb begin
      logic n, z, c, v;
      {n, z, c, v} = flags;
      cond_ok = 1'b0;
      case (cond)
         4'b0000: cond_ok = z;
         4'b0001: cond_ok = ~z;
         4'b0010: cond_ok = c;
         4'b0011: cond_ok = ~c;
         4'b0100: cond_ok = n;
         4'b0101: cond_ok = ~n;
         4'b0110: cond_ok = v;
         4'b0111: cond_ok = ~v;
         4'b1000: cond_ok = c & ~z;
         4'b1001: cond_ok = ~(c & ~z);
         4'b1010: cond_ok = (n == v);
         4'b1011: cond_ok = (n != v);
         4'b1100: cond_ok = ~z & (n == v);
         4'b1101: cond_ok = ~(~z & (n == v));
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // Next-state and per-state control outputs; strobes are squashed while in reset.
   always_comb begin
      next_state = state;
      MemReq     = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = ALU_ADD;
      case (state)
         FETCH: begin
            MemReq    = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = rdy;
            PCWrite   = rdy;
            if (rdy) next_state = DECODE;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (!cond_ok || op == 2'b11) next_state = FETCH;
            else if (op == 2'b00)        next_state = funct[5] ? EXECI : EXECR;
            else if (op == 2'b01)        next_state = MEMADR;
            else                         next_state = BRANCH;
         end
         MEMADR: begin
            ALUSrcB    = 2'b01;
            next_state = funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            MemReq = 1'b1;
            AdrSrc = 1'b1;
            if (rdy) next_state = MEMWB;
         end
         MEMWB: begin
            ResultSrc  = 2'b01;
            RegWrite   = 1'b1;
            next_state = FETCH;
         end
         MEMWR: begin
            MemReq   = 1'b1;
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (rdy) next_state = FETCH;
         end
         EXECR, EXECI: begin
            ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
            ALUControl = alu_op;
            next_state = is_cmp ? FETCH : ALUWB;
         end
         ALUWB: begin
            RegWrite   = 1'b1;
            next_state = FETCH;
         end
         BRANCH: begin
            ALUSrcB    = 2'b01;
            ResultSrc  = 2'b10;
            PCWrite    = 1'b1;
            next_state = FETCH;
         end
         default: next_state = FETCH;
      endcase
      if (timeout) next_state = FETCH;
      if (reset) begin
         MemReq   = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

   assign MemErr = timeout & ~reset;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   // Wait counter: counts stalled cycles, cleared on any state change or abort.
   always_ff @(posedge clk) begin
      if (reset)                                wait_cnt <= '0;
      else if (next_state != state || timeout)  wait_cnt <= '0;
      else if (in_wait && !rdy)                 wait_cnt <= wait_cnt + 1'b1;
   end

   // Flag register: NZ on S or CMP; CV only for arithmetic operations.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= 4'b0000;
      end else if ((state == EXECR || state == EXECI) && (funct[0] || is_cmp)) begin
         flags[3:2] <= ALUFlags[3:2];
         if (alu_op == ALU_ADD || alu_op == ALU_SUB) flags[1:0] <= ALUFlags[1:0];
      end
   end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller (TIMEOUT=4): walks ADD, LDR with waits,
// CMP/BEQ/BNE, MOVS, STR timeout, FETCH timeout and reset during a wait.
module tb_arm_mc_controller;

   logic        clk;
   logic        reset;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        MemReady;
   logic        MemReq, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
   logic [1:0]  RegSrc;
   logic [2:0]  ImmSrc;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB, ResultSrc;
   logic [2:0]  ALUControl;
   logic        MemErr;
   logic [3:0]  State;

   int n_chk  = 0;
   int n_fail = 0;

   arm_mc_controller #(.WAIT_EN(1'b1), .TIMEOUT(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
      .MemReq(MemReq), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ALUControl(ALUControl), .MemErr(MemErr), .State(State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [31:0] w);
      Instr = w[31:12];
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a ready memory: strobes must stay low.
      reset = 1'b1; MemReady = 1'b1; ALUFlags = 4'h0;
      set_instr(32'hE0812002);
      tick(); tick();
      chk("rst_state",   State,     0);
      chk("rst_irwrite", IRWrite,   0);
      chk("rst_pcwrite", PCWrite,   0);
      chk("rst_memreq",  MemReq,    0);
      chk("rst_memerr",  MemErr,    0);
      chk("rst_flags",   dut.flags, 0);

      // ADD R2,R1,R2 (no S): 0 -> 1 -> 6 -> 8 -> 0, flags untouched.
      reset = 1'b0; ALUFlags = 4'hF; #1;
      chk("add_fetch_irw", IRWrite, 1);
      chk("add_fetch_pcw", PCWrite, 1);
      chk("add_fetch_req", MemReq,  1);
      tick(); chk("add_s1", State, 1); chk("add_dec_rw", RegWrite, 0);
      tick(); chk("add_s6", State, 6); chk("add_aluctl", ALUControl, 0);
      chk("add_srcb", ALUSrcB, 0); chk("add_exec_rw", RegWrite, 0);
      tick(); chk("add_s8", State, 8); chk("add_wb_rw", RegWrite, 1); chk("add_wb_res", ResultSrc, 0);
      tick(); chk("add_s0", State, 0); chk("add_flags", dut.flags, 0);

      // LDR with three not-ready cycles in MEMRD.
      set_instr(32'hE5910004); ALUFlags = 4'h0; #1;
      tick(); chk("ldr_s1", State, 1);
      tick(); chk("ldr_s2", State, 2); chk("ldr_srcb", ALUSrcB, 1);
      MemReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ldr_wait_s3",  State,  3);
         chk("ldr_wait_req", MemReq, 1);
         chk("ldr_wait_adr", AdrSrc, 1);
      end
      tick(); MemReady = 1'b1; #1;
      chk("ldr_rdy_s3", State, 3); chk("ldr_rdy_req", MemReq, 1); chk("ldr_rdy_err", MemErr, 0);
      tick(); chk("ldr_s4", State, 4); chk("ldr_res", ResultSrc, 1); chk("ldr_rw", RegWrite, 1);
      tick(); chk("ldr_s0", State, 0);

      // CMP R1,#0 with Z from the ALU; no register write.
      set_instr(32'hE3510000); #1;
      tick(); chk("cmp_s1", State, 1);
      tick(); ALUFlags = 4'b0100; #1;
      chk("cmp_s7", State, 7); chk("cmp_aluctl", ALUControl, 1); chk("cmp_rw", RegWrite, 0);
      tick(); chk("cmp_s0", State, 0); chk("cmp_flags", dut.flags, 4'b0100);

      // BEQ taken on stored Z.
      set_instr(32'h0A000001); ALUFlags = 4'h0; #1;
      tick(); chk("beq_s1", State, 1); chk("beq_dec_pcw", PCWrite, 0);
      tick(); chk("beq_s9", State, 9); chk("beq_pcw", PCWrite, 1); chk("beq_srcb", ALUSrcB, 1);
      tick(); chk("beq_s0", State, 0); chk("beq_flags", dut.flags, 4'b0100);

      // BNE not taken: straight back to FETCH.
      set_instr(32'h1A000001); #1;
      tick(); chk("bne_s1", State, 1); chk("bne_pcw", PCWrite, 0); chk("bne_rw", RegWrite, 0);
      tick(); chk("bne_s0", State, 0);

      // CMP loading N=1 so MOVS has NZ to change.
      set_instr(32'hE3510000); #1;
      tick(); tick(); ALUFlags = 4'b1000; #1;
      chk("cmp2_s7", State, 7);
      tick(); chk("cmp2_flags", dut.flags, 4'b1000);

      // MOVS R0,#0 with ALU NZCV=0111: NZ=01 stored, CV keeps 00.
      set_instr(32'hE3B00000); ALUFlags = 4'h0; #1;
      tick(); chk("movs_s1", State, 1);
      tick(); ALUFlags = 4'b0111; #1;
      chk("movs_s7", State, 7); chk("movs_aluctl", ALUControl, 4); chk("movs_exec_rw", RegWrite, 0);
      tick(); ALUFlags = 4'h0; #1;
      chk("movs_s8", State, 8); chk("movs_rw", RegWrite, 1); chk("movs_flags", dut.flags, 4'b0100);
      tick(); chk("movs_s0", State, 0);

      // STR with memory never ready: abort on the 4th MEMWR cycle.
      set_instr(32'hE5812000); #1;
      tick(); chk("str_s1", State, 1);
      tick(); chk("str_s2", State, 2); MemReady = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("str_wait_s5", State,    5);
         chk("str_wait_mw", MemWrite, 1);
         chk("str_wait_err", MemErr,  0);
      end
      tick(); chk("str_to_s5", State, 5); chk("str_to_mw", MemWrite, 1); chk("str_to_err", MemErr, 1);
      tick(); chk("str_abort_s0", State, 0); chk("str_abort_mw", MemWrite, 0);
      chk("str_abort_err", MemErr, 0); chk("str_abort_irw", IRWrite, 0);

      // FETCH also times out while memory stays busy.
      for (int i = 0; i < 2; i++) begin
         tick(); chk("fto_wait_err", MemErr, 0); chk("fto_wait_s0", State, 0);
      end
      tick(); chk("fto_err", MemErr, 1); chk("fto_pcw", PCWrite, 0); chk("fto_s0", State, 0);
      tick(); chk("fto_clr_err", MemErr, 0);

      // Reset while MEMRD is waiting.
      MemReady = 1'b1; set_instr(32'hE5910004); #1;
      tick(); tick(); chk("rmw_s2", State, 2); MemReady = 1'b0; #1;
      tick(); tick(); chk("rmw_s3", State, 3);
      reset = 1'b1; #1;
      chk("rmw_req_forced", MemReq, 0);
      tick(); chk("rmw_s0", State, 0); chk("rmw_flags", dut.flags, 0); chk("rmw_err", MemErr, 0);
      reset = 1'b0; MemReady = 1'b1; #1;
      chk("rmw_irw", IRWrite, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
